// File: rtl/psdsqrt_pkg.sv
// rtl/psdsqrt_pkg.sv - shared types and constants for the iterative square-root unit
// State encoding, default operand width and counter sizing helper.
package psdsqrt_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    ITER = 1'b1
  } state_t;

  localparam int DEFAULT_NUM_BITS = 32;

  // One counter value per root bit; never narrower than one bit.
  function automatic int cnt_width(input int num_bits);
    return ((num_bits / 2) <= 2) ? 1 : $clog2(num_bits / 2);
  endfunction

endpackage

// File: rtl/psdsqrt_step.sv
// rtl/psdsqrt_step.sv - one combinational restoring square-root iteration
// Consumes two operand bits and produces one root bit plus the updated remainder.
module psdsqrt_step #(
  parameter int RW = 16
) (
  input  logic [RW+1:0] rem_in,
  input  logic [RW-1:0] root_in,
  input  logic [1:0]    bits,
  output logic [RW+1:0] rem_out,
  output logic [RW-1:0] root_out
);

  logic [RW+1:0] rem_shift;
  logic [RW+1:0] trial;
  logic          take;
  logic          unused_top;

  // Before any iteration rem <= 2*root < 2^RW, so the two top rem bits and
  // the top root bit are always zero here and can be dropped by the shift.
  assign rem_shift  = {rem_in[RW-1:0], bits};
  assign trial      = {root_in, 2'b01};
  assign take       = (rem_shift >= trial);
  assign unused_top = ^{rem_in[RW+1:RW], root_in[RW-1]};

  assign rem_out  = take ? (rem_shift - trial) : rem_shift;
  assign root_out = {root_in[RW-2:0], take};

endmodule

// File: rtl/psdsqrt_iter.sv
// rtl/psdsqrt_iter.sv - sequential digit-by-digit integer square root, one root bit per clock
// Optional round-to-nearest result selected by PSDSQRT_ROUND_EN.
module psdsqrt_iter
  import psdsqrt_pkg::*;
#(
  parameter int NUM_BITS = DEFAULT_NUM_BITS
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic                  stop,
  input  logic [NUM_BITS-1:0]   xin,
  output logic                  busy,
  output logic                  done,
  output logic [NUM_BITS/2-1:0] sqrt,
  output logic [NUM_BITS/2:0]   rem
);

  localparam int RW = NUM_BITS / 2;
  localparam int CW = cnt_width(NUM_BITS);

  if (((NUM_BITS % 2) != 0) || (NUM_BITS < 4)) begin : g_bad_width
    $fatal(1, "psdsqrt_iter: NUM_BITS must be even and >= 4");
  end

  state_t              state;
  logic [CW-1:0]       cnt;
  logic [NUM_BITS-1:0] opnd;
  logic [RW-1:0]       root_q;
  logic [RW+1:0]       rem_q;

  logic [RW-1:0]       root_nx;
  logic [RW+1:0]       rem_nx;
  logic [RW-1:0]       sqrt_fin;
  logic                unused_rem_msb;

  psdsqrt_step #(.RW(RW)) u_step (
    .rem_in   (rem_q),
    .root_in  (root_q),
    .bits     (opnd[NUM_BITS-1:NUM_BITS-2]),
    .rem_out  (rem_nx),
    .root_out (root_nx)
  );

  // The final remainder is at most 2*root, so it always fits in RW+1 bits.
  assign unused_rem_msb = rem_nx[RW+1];

`ifdef PSDSQRT_ROUND_EN
  logic round_up;
  assign round_up = (rem_nx > {2'b00, root_nx});
  assign sqrt_fin = (round_up && (root_nx != {RW{1'b1}})) ? root_nx + 1'b1 : root_nx;
`else
  assign sqrt_fin = root_nx;
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      cnt    <= '0;
      opnd   <= '0;
      root_q <= '0;
      rem_q  <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      sqrt   <= '0;
      rem    <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            opnd   <= xin;
            root_q <= '0;
            rem_q  <= '0;
            cnt    <= CW'(RW - 1);
            busy   <= 1'b1;
            state  <= ITER;
          end
        end
        ITER: begin
          // Abort takes priority even over the final iteration.
          if (stop) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            opnd   <= opnd << 2;
            root_q <= root_nx;
            rem_q  <= rem_nx;
            if (cnt == '0) begin
              sqrt  <= sqrt_fin;
              rem   <= rem_nx[RW:0];
              done  <= 1'b1;
              busy  <= 1'b0;
              state <= IDLE;
            end else begin
              cnt <= cnt - 1'b1;
            end
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_psdsqrt_iter.sv
// tb/tb_psdsqrt_iter.sv - directed self-checking bench for psdsqrt_iter (NUM_BITS=32)
// Expected roots follow PSDSQRT_ROUND_EN when it is defined.
module tb_psdsqrt_iter;

`ifdef PSDSQRT_ROUND_EN
  localparam bit RND = 1'b1;
`else
  localparam bit RND = 1'b0;
`endif

  logic        clock;
  logic        reset_n;
  logic        start;
  logic        stop;
  logic [31:0] xin;
  logic        busy;
  logic        done;
  logic [15:0] sqrt;
  logic [16:0] rem;

  int total = 0;
  int bad   = 0;

  psdsqrt_iter #(.NUM_BITS(32)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .start   (start),
    .stop    (stop),
    .xin     (xin),
    .busy    (busy),
    .done    (done),
    .sqrt    (sqrt),
    .rem     (rem)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic launch(input logic [31:0] x);
    start = 1'b1;
    xin   = x;
    tick();
    start = 1'b0;
  endtask

  // Returns the number of edges until done is seen, 0 if the bound expires.
  task automatic wait_done(input int limit, output int edges, output int busy_cnt);
    edges    = 0;
    busy_cnt = 0;
    for (int n = 1; n <= limit; n++) begin
      tick();
      if (done) begin
        edges = n;
        break;
      end
      if (busy) busy_cnt++;
    end
  endtask

  task automatic run_op(input string tag, input logic [31:0] x,
                        input logic [15:0] exp_sqrt, input logic [16:0] exp_rem);
    int e, b;
    launch(x);
    wait_done(40, e, b);
    chk({tag, "_lat"}, e, 16);
    chk({tag, "_sqrt"}, sqrt, exp_sqrt);
    chk({tag, "_rem"}, rem, exp_rem);
  endtask

  initial begin
    int e, b;
    reset_n = 1'b0;
    start   = 1'b0;
    stop    = 1'b0;
    xin     = '0;
    tick();
    tick();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_sqrt", sqrt, 0);
    chk("rst_rem", rem, 0);
    reset_n = 1'b1;
    tick();

    // Zero operand: latency, busy duration and single-cycle done
    launch(32'd0);
    chk("zero_busy0", busy, 1);
    wait_done(40, e, b);
    chk("zero_lat", e, 16);
    chk("zero_busycnt", b + 1, 16);
    chk("zero_busy_at_done", busy, 0);
    chk("zero_sqrt", sqrt, 0);
    chk("zero_rem", rem, 0);
    tick();
    chk("zero_done_pulse", done, 0);

    run_op("m1", 32'd1000000, 16'd1000, 17'd0);
    run_op("n99", 32'd99, RND ? 16'd10 : 16'd9, 17'd18);
    run_op("max", 32'hFFFF_FFFF, 16'd65535, 17'd131070);
    run_op("n15", 32'd15, RND ? 16'd4 : 16'd3, 17'd6);
    run_op("n16", 32'd16, 16'd4, 17'd0);
    run_op("n2", 32'd2, 16'd1, 17'd1);
    run_op("n3", 32'd3, RND ? 16'd2 : 16'd1, 17'd2);
    tick();

    // Start while busy is ignored; start in the done cycle is accepted
    launch(32'd99);
    repeat (4) tick();
    start = 1'b1;
    xin   = 32'd4;
    tick();
    start = 1'b0;
    wait_done(40, e, b);
    chk("busy_start_lat", e, 11);
    chk("busy_start_sqrt", sqrt, RND ? 16'd10 : 16'd9);
    chk("busy_start_rem", rem, 18);
    run_op("b2b", 32'd4, 16'd2, 17'd0);
    tick();

    // Abort mid-operation
    launch(32'd99);
    repeat (7) tick();
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("stop_busy", busy, 0);
    wait_done(25, e, b);
    chk("stop_nodone", e, 0);
    chk("stop_sqrt", sqrt, 2);
    chk("stop_rem", rem, 0);

    // Abort on the final-iteration edge
    launch(32'd99);
    repeat (15) tick();
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("stoplast_done", done, 0);
    chk("stoplast_busy", busy, 0);
    wait_done(25, e, b);
    chk("stoplast_nodone", e, 0);
    chk("stoplast_sqrt", sqrt, 2);

    // Asynchronous reset mid-operation
    launch(32'd1000000);
    repeat (5) tick();
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    chk("arst_sqrt", sqrt, 0);
    chk("arst_rem", rem, 0);
    tick();
    reset_n = 1'b1;
    wait_done(25, e, b);
    chk("arst_nodone", e, 0);
    run_op("after_rst", 32'd144, 16'd12, 17'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/psdsqrt_iter.md
Name: psdsqrt_iter

Overview:
Parametrised, sequential successor to the single-cycle square-root datapath. Computes the integer square root and remainder of an unsigned NUM_BITS operand using the digit-by-digit (restoring) method, one result bit per clock. Uses a start/busy/done handshake with an abort input. Sits between the operand register file and the result bus of the PSD arithmetic unit.

Parameters:
NUM_BITS, 32, operand width; must be even and >= 4 (elaboration-time check, fatal otherwise)
RW, NUM_BITS/2, root width (derived, localparam)

Ports:
clock  input  1  master clock, rising edge
reset_n  input  1  asynchronous reset, active-low
start  input  1  one-cycle pulse; launches operation when idle
stop  input  1  one-cycle pulse; aborts operation when busy
xin  input  NUM_BITS  unsigned operand, sampled on accepted start
busy  output  1  high while iterating
done  output  1  one-cycle pulse, result valid
sqrt  output  RW  floor(sqrt(xin)), or rounded (see Optional Feature)
rem  output  RW+1  xin - floor_root^2

Behaviour:
- Reset (reset_n low, asynchronous): state IDLE; busy=0, done=0, sqrt=0, rem=0; internal operand/partial registers cleared.
- States: IDLE, ITER.
- IDLE: start=1 at edge E0 -> latch xin into shift register, partial root=0, partial rem=0, counter=RW-1, go ITER, busy=1. stop ignored in IDLE. start+stop together in IDLE -> start accepted.
- ITER, each edge:
  - r' = (rem<<2) | top two operand bits; operand <<= 2.
  - trial = (root<<2)|1.
  - if r' >= trial: rem = r'-trial, root = (root<<1)|1; else rem = r', root = root<<1.
- Internal rem is RW+2 bits; no overflow is possible.
- Counter==0 at edge E(RW): final root/rem written to sqrt/rem; done=1 for exactly one cycle; busy=0; back to IDLE.
- Latency: done is high in the cycle after edge E0+RW (16 edges after start for NUM_BITS=32).
- start while busy: ignored, no effect on operation in flight.
- stop while busy: abort at that edge -> IDLE, busy=0, no done; sqrt/rem keep previous values. stop on the same edge as the final iteration -> abort wins, no done.
- start in the cycle where done=1: accepted (state is IDLE); back-to-back throughput is RW+1 cycles.
- sqrt/rem change only on done; held stable otherwise.
- reset_n asserted mid-operation: immediate return to reset values; no done.

Optional Feature:
PSDSQRT_ROUND_EN
- Defined: sqrt is round-to-nearest. If final rem > final root, sqrt = root+1, saturated at 2^RW-1. rem output is always the floor remainder (unchanged). Rounding is combinational on the final-iteration edge; latency unchanged.
- Undefined: sqrt is floor(sqrt(xin)); no rounding logic is present.

Decomposition:
- Package psdsqrt_pkg: state enum type (IDLE, ITER); default NUM_BITS constant; function computing counter width, $clog2(NUM_BITS/2).
- Sub-module psdsqrt_step: purely combinational single iteration. Inputs: rem, root, two operand bits. Outputs: next rem, next root. Parameterised by RW.
- Top-level holds the FSM, counter, registers and rounding.

Test Plan:
- NUM_BITS=32, xin=0, start pulse -> done exactly 16 edges later; sqrt=0, rem=0; busy high for 16 cycles.
- xin=1000000 -> sqrt=1000, rem=0. xin=99 -> sqrt=9, rem=18; with PSDSQRT_ROUND_EN, sqrt=10.
- xin=32'hFFFFFFFF -> sqrt=65535, rem=131070; with PSDSQRT_ROUND_EN, sqrt stays 65535 (saturation).
- Start xin=99, then start with xin=4 at cycle 5 -> second start ignored; result 9/18. Then start issued in the done cycle with xin=4 -> accepted; sqrt=2, rem=0.
- Start xin=99, stop at cycle 8 -> busy drops, no done, sqrt/rem hold prior values. Repeat with stop on the final-iteration edge -> no done.
- Start, then reset_n low for 1 cycle at cycle 6 -> all outputs 0 immediately, no done. Fresh start afterwards completes normally.
- Random regression: 10k operands at NUM_BITS=8, 16 and 32; check sqrt^2 <= xin < (sqrt+1)^2 and rem == xin - sqrt^2 (floor build).
